// File: rtl/cod_seletor_entrada.sv
// Input selector: synchronizes and debounces the switch code and two buttons, then
// drives a 5-bit code either loaded from the switches (MANUAL) or auto-stepped (SCAN).
module cod_seletor_entrada #(
  parameter int DEB_CYCLES = 1000,
  parameter int SCAN_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sw,
  input  logic       btn_load,
  input  logic       btn_mode,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       valid,
  output logic       mode
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  // Button index 0 is load, index 1 is mode.
  localparam int LOAD = 0;
  localparam int MODE = 1;

  logic [4:0]          sw_meta_q, sw_meta_d;
  logic [4:0]          sw_sync_q, sw_sync_d;
  logic [1:0]          btn_meta_q, btn_meta_d;
  logic [1:0]          btn_sync_q, btn_sync_d;
  logic [1:0]          deb_lvl_q, deb_lvl_d;
  logic [1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]          press_q, press_d;
  logic [4:0]          code_q, code_d;
  logic                valid_q, valid_d;
  logic                mode_q, mode_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_s;

  // Next-state logic: synchronizers, debouncers, press events, code/mode control.
  always_comb begin
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = {btn_mode, btn_load};
    btn_sync_d = btn_meta_q;
    deb_lvl_d  = deb_lvl_q;
    deb_cnt_d  = deb_cnt_q;
    press_d    = 2'b00;
    code_d     = code_q;
    valid_d    = 1'b0;
    mode_d     = mode_q;
    pre_d      = pre_q;

    for (int i = 0; i < 2; i++) begin
      if (btn_sync_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        // The press event is registered alongside the level flip, so it fires once per rise.
        deb_cnt_d[i] = '0;
        deb_lvl_d[i] = btn_sync_q[i];
        press_d[i]   = btn_sync_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end

    tick_s = mode_q && (pre_q == PRE_LAST);

    if (press_q[MODE]) begin
      // A mode toggle wins over a coincident scan tick; a manual load still lands.
      mode_d = ~mode_q;
      pre_d  = '0;
      if (!mode_q && press_q[LOAD]) begin
        code_d  = sw_sync_q;
        valid_d = 1'b1;
      end else begin
        code_d  = code_q;
      end
    end else if (mode_q) begin
      if (tick_s) begin
        pre_d   = '0;
        code_d  = code_q + 5'd1;
        valid_d = 1'b1;
      end else begin
        pre_d   = pre_q + PW'(1);
      end
    end else begin
      pre_d = '0;
      if (press_q[LOAD]) begin
        code_d  = sw_sync_q;
        valid_d = 1'b1;
      end else begin
        code_d  = code_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= 5'd0;
      sw_sync_q  <= 5'd0;
      btn_meta_q <= 2'b00;
      btn_sync_q <= 2'b00;
      deb_lvl_q  <= 2'b00;
      deb_cnt_q  <= '0;
      press_q    <= 2'b00;
      code_q     <= 5'd0;
      valid_q    <= 1'b0;
      mode_q     <= 1'b0;
      pre_q      <= '0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      btn_meta_q <= btn_meta_d;
      btn_sync_q <= btn_sync_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_cnt_q  <= deb_cnt_d;
      press_q    <= press_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      mode_q     <= mode_d;
      pre_q      <= pre_d;
    end
  end

  assign {A, B, C, D, E} = code_q;
  assign valid           = valid_q;
  assign mode            = mode_q;

endmodule

// File: tb/tb_cod_seletor_entrada.sv
// Directed bench for cod_seletor_entrada with DEB_CYCLES=4, SCAN_DIV=3.
module tb_cod_seletor_entrada;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sw;
  logic       btn_load;
  logic       btn_mode;
  logic       A, B, C, D, E;
  logic       valid;
  logic       mode;
  logic [4:0] code_s;

  int n_checks = 0;
  int n_pass   = 0;

  cod_seletor_entrada #(.DEB_CYCLES(4), .SCAN_DIV(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_mode(btn_mode),
    .A(A), .B(B), .C(C), .D(D), .E(E), .valid(valid), .mode(mode)
  );

  assign code_s = {A, B, C, D, E};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] e_code;
    int j;

    rst = 1'b1; sw = 5'd0; btn_load = 1'b0; btn_mode = 1'b0;
    tick(2);
    chk("rst_code", code_s, 5'b00000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_mode", mode, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("rst_code_after", code_s, 5'b00000);

    // Manual load: valid exactly 7 cycles after the rise, once.
    sw = 5'b10110; btn_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("load_valid", valid, (i == 7));
      chk("load_code", code_s, (i >= 7) ? 5'b10110 : 5'b00000);
    end
    btn_load = 1'b0; sw = 5'b01010;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      chk("release_valid", valid, 1'b0);
      chk("sw_no_load_code", code_s, 5'b10110);
    end

    // Bounce: two-cycle pulses never satisfy a four-cycle debounce.
    sw = 5'b00011;
    for (int i = 0; i < 10; i++) begin
      btn_load = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        chk("bounce_valid", valid, 1'b0);
        chk("bounce_code", code_s, 5'b10110);
      end
    end
    btn_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("bounce_tail_valid", valid, 1'b0);
      chk("bounce_tail_code", code_s, 5'b10110);
    end

    // Scan wrap from 11110, with an ignored load press during scan.
    sw = 5'b11110; btn_load = 1'b1;
    tick(7);
    chk("scan_pre_load_code", code_s, 5'b11110);
    chk("scan_pre_load_valid", valid, 1'b1);
    btn_load = 1'b0;
    tick(8);
    btn_mode = 1'b1; sw = 5'b01100;
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      j = k - 7;
      e_code = (k < 7) ? 5'b11110 : 5'(5'b11110 + 5'(j / 3));
      chk("scan_mode", mode, (k >= 7));
      chk("scan_code", code_s, e_code);
      chk("scan_valid", valid, (k >= 7) && (j > 0) && (j % 3 == 0));
      if (k == 8) begin
        btn_mode = 1'b0;
        btn_load = 1'b1;
      end else if (k == 16) begin
        btn_load = 1'b0;
      end else begin
        btn_load = btn_load;
      end
    end

    // Mode press lands on a terminal count: mode leaves, code holds, no valid.
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      e_code = (k < 3) ? 5'b00010 : (k < 6) ? 5'b00011 : 5'b00100;
      chk("coll_mode", mode, (k < 9));
      chk("coll_code", code_s, e_code);
      chk("coll_valid", valid, (k == 3) || (k == 6));
      if (k == 2) btn_mode = 1'b1;
    end
    btn_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("manual_hold_mode", mode, 1'b0);
      chk("manual_hold_code", code_s, 5'b00100);
      chk("manual_hold_valid", valid, 1'b0);
    end

    // Reset mid-scan with btn_mode held through and past reset.
    btn_mode = 1'b1;
    tick(10);
    chk("pre_rst_mode", mode, 1'b1);
    chk("pre_rst_code", code_s, 5'b00101);
    chk("pre_rst_valid", valid, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_code", code_s, 5'b00000);
    chk("mid_rst_mode", mode, 1'b0);
    chk("mid_rst_valid", valid, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      chk("held_mode", mode, (k >= 7));
      chk("held_code", code_s, (k >= 10) ? 5'b00001 : 5'b00000);
      chk("held_valid", valid, (k == 10));
    end
    btn_mode = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
